// File: rtl/coeff_stream_loader.sv
// coeff_stream_loader
// Writer side of the coefficient register bank. It accepts one neuron's
// coefficient set as a serial stream of 21 signed words over a valid/ready
// handshake. Words 0..19 are staged as weights and word 20 as the offset.
// Once the set is complete it issues a one-cycle EnableRegisterIn strobe so
// the bank captures all 21 values atomically.
//
// Ports:
//   CLK              rising-edge clock
//   reset            asynchronous active-high reset
//   StartLoad        begin a new load (honoured only in IDLE)
//   Abort            cancel a load in progress (honoured only in LOAD)
//   DataIn           signed coefficient word
//   DataValid        DataIn is valid this cycle
//   DataReady        loader accepts DataIn this cycle (registered)
//   Coeff00..Coeff19 staged weights to the bank
//   OffsetOut        staged offset to the bank OffsetIn
//   EnableRegisterIn one-cycle commit strobe to the bank
//   WordCount        words accepted in the current load (0..21)
//   Busy             high in LOAD and COMMIT
//   LoadDone         one-cycle pulse the cycle after the commit
module coeff_stream_loader #(
    parameter int Width = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             StartLoad,
    input  logic             Abort,
    input  logic [Width-1:0] DataIn,
    input  logic             DataValid,
    output logic             DataReady,
    output logic [Width-1:0] Coeff00,
    output logic [Width-1:0] Coeff01,
    output logic [Width-1:0] Coeff02,
    output logic [Width-1:0] Coeff03,
    output logic [Width-1:0] Coeff04,
    output logic [Width-1:0] Coeff05,
    output logic [Width-1:0] Coeff06,
    output logic [Width-1:0] Coeff07,
    output logic [Width-1:0] Coeff08,
    output logic [Width-1:0] Coeff09,
    output logic [Width-1:0] Coeff10,
    output logic [Width-1:0] Coeff11,
    output logic [Width-1:0] Coeff12,
    output logic [Width-1:0] Coeff13,
    output logic [Width-1:0] Coeff14,
    output logic [Width-1:0] Coeff15,
    output logic [Width-1:0] Coeff16,
    output logic [Width-1:0] Coeff17,
    output logic [Width-1:0] Coeff18,
    output logic [Width-1:0] Coeff19,
    output logic [Width-1:0] OffsetOut,
    output logic             EnableRegisterIn,
    output logic [4:0]       WordCount,
    output logic             Busy,
    output logic             LoadDone
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [Width-1:0] coeff_r [0:19];
    logic [Width-1:0] offset_r;
    logic [4:0]       word_count_r;
    logic             data_ready_r;
    logic             enable_r;
    logic             busy_r;
    logic             load_done_r;

    // A transfer only happens while LOAD holds DataReady high.
    logic             handshake_s;
    assign handshake_s = DataValid & data_ready_r;

    // Loader FSM: drives the handshake, stages words and emits the commit strobe.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            for (int i = 0; i < 20; i++) begin
                coeff_r[i] <= {Width{1'b0}};
            end
            offset_r     <= {Width{1'b0}};
            word_count_r <= 5'd0;
            data_ready_r <= 1'b0;
            enable_r     <= 1'b0;
            busy_r       <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            enable_r    <= 1'b0;
            load_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (StartLoad) begin
                        state_r      <= LOAD;
                        word_count_r <= 5'd0;
                        data_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        data_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                LOAD: begin
                    // Abort wins over a coincident handshake: the word is dropped.
                    if (Abort) begin
                        state_r      <= IDLE;
                        data_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end else if (handshake_s) begin
                        word_count_r <= word_count_r + 5'd1;
                        if (word_count_r == 5'd20) begin
                            offset_r     <= DataIn;
                            state_r      <= COMMIT;
                            data_ready_r <= 1'b0;
                            enable_r     <= 1'b1;
                        end else begin
                            coeff_r[word_count_r] <= DataIn;
                        end
                    end else begin
                        data_ready_r <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_r      <= IDLE;
                    data_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                    load_done_r  <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    data_ready_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign DataReady        = data_ready_r;
    assign EnableRegisterIn = enable_r;
    assign WordCount        = word_count_r;
    assign Busy             = busy_r;
    assign LoadDone         = load_done_r;
    assign OffsetOut        = offset_r;
    assign Coeff00 = coeff_r[0];
    assign Coeff01 = coeff_r[1];
    assign Coeff02 = coeff_r[2];
    assign Coeff03 = coeff_r[3];
    assign Coeff04 = coeff_r[4];
    assign Coeff05 = coeff_r[5];
    assign Coeff06 = coeff_r[6];
    assign Coeff07 = coeff_r[7];
    assign Coeff08 = coeff_r[8];
    assign Coeff09 = coeff_r[9];
    assign Coeff10 = coeff_r[10];
    assign Coeff11 = coeff_r[11];
    assign Coeff12 = coeff_r[12];
    assign Coeff13 = coeff_r[13];
    assign Coeff14 = coeff_r[14];
    assign Coeff15 = coeff_r[15];
    assign Coeff16 = coeff_r[16];
    assign Coeff17 = coeff_r[17];
    assign Coeff18 = coeff_r[18];
    assign Coeff19 = coeff_r[19];

endmodule

// File: tb/tb_coeff_stream_loader.sv
// Directed self-checking bench for coeff_stream_loader (Width = 8).
module tb_coeff_stream_loader;

    logic       CLK;
    logic       reset;
    logic       StartLoad;
    logic       Abort;
    logic [7:0] DataIn;
    logic       DataValid;
    logic       DataReady;
    logic [7:0] c [0:19];
    logic [7:0] OffsetOut;
    logic       EnableRegisterIn;
    logic [4:0] WordCount;
    logic       Busy;
    logic       LoadDone;

    int vectors;
    int miscompares;
    int en_count;
    logic [7:0] words [0:20];

    coeff_stream_loader #(.Width(8)) dut (
        .CLK(CLK), .reset(reset), .StartLoad(StartLoad), .Abort(Abort),
        .DataIn(DataIn), .DataValid(DataValid), .DataReady(DataReady),
        .Coeff00(c[0]),  .Coeff01(c[1]),  .Coeff02(c[2]),  .Coeff03(c[3]),
        .Coeff04(c[4]),  .Coeff05(c[5]),  .Coeff06(c[6]),  .Coeff07(c[7]),
        .Coeff08(c[8]),  .Coeff09(c[9]),  .Coeff10(c[10]), .Coeff11(c[11]),
        .Coeff12(c[12]), .Coeff13(c[13]), .Coeff14(c[14]), .Coeff15(c[15]),
        .Coeff16(c[16]), .Coeff17(c[17]), .Coeff18(c[18]), .Coeff19(c[19]),
        .OffsetOut(OffsetOut), .EnableRegisterIn(EnableRegisterIn),
        .WordCount(WordCount), .Busy(Busy), .LoadDone(LoadDone)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count commit strobes seen at clock edges.
    always @(posedge CLK) begin
        if (EnableRegisterIn === 1'b1) en_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_staged(input string tag);
        for (int i = 0; i < 20; i++) check($sformatf("%s_coeff%0d", tag, i), {24'd0, c[i]}, {24'd0, words[i]});
        check({tag, "_offset"}, {24'd0, OffsetOut}, {24'd0, words[20]});
    endtask

    // Full 21-word load of words[]; optional 3-cycle gaps after every 4th word,
    // optional StartLoad pokes during LOAD and COMMIT plus a 22nd word offer.
    task automatic run_load(input string tag, input bit gaps, input bit pokes);
        int en_before;
        en_before = en_count;
        StartLoad = 1'b1;
        step();
        StartLoad = 1'b0;
        check({tag, "_start_ready"}, {31'd0, DataReady}, 32'd1);
        check({tag, "_start_busy"}, {31'd0, Busy}, 32'd1);
        check({tag, "_start_count"}, {27'd0, WordCount}, 32'd0);
        for (int k = 0; k < 21; k++) begin
            if (gaps && k > 0 && (k % 4) == 0) begin
                DataValid = 1'b0;
                DataIn    = 8'hEE;
                step(); step(); step();
                check($sformatf("%s_gap_count%0d", tag, k), {27'd0, WordCount}, k);
            end
            DataValid = 1'b1;
            DataIn    = words[k];
            StartLoad = (pokes && k == 5) ? 1'b1 : 1'b0;
            step();
            StartLoad = 1'b0;
            if (k == 5 || k == 20) begin
                check($sformatf("%s_count%0d", tag, k), {27'd0, WordCount}, k + 1);
            end
        end
        DataValid = 1'b0;
        check({tag, "_commit_en"}, {31'd0, EnableRegisterIn}, 32'd1);
        check({tag, "_commit_ready"}, {31'd0, DataReady}, 32'd0);
        check({tag, "_commit_busy"}, {31'd0, Busy}, 32'd1);
        if (pokes) begin
            StartLoad = 1'b1;
            DataValid = 1'b1;
            DataIn    = 8'h55;
        end
        step();
        StartLoad = 1'b0;
        check({tag, "_done_pulse"}, {31'd0, LoadDone}, 32'd1);
        check({tag, "_done_en"}, {31'd0, EnableRegisterIn}, 32'd0);
        check({tag, "_done_count"}, {27'd0, WordCount}, 32'd21);
        check({tag, "_done_busy"}, {31'd0, Busy}, 32'd0);
        step();
        DataValid = 1'b0;
        check({tag, "_after_done"}, {31'd0, LoadDone}, 32'd0);
        check({tag, "_after_ready"}, {31'd0, DataReady}, 32'd0);
        check({tag, "_after_count"}, {27'd0, WordCount}, 32'd21);
        check({tag, "_en_pulses"}, en_count - en_before, 32'd1);
        check_staged(tag);
    endtask

    initial begin
        int en_before;
        vectors = 0; miscompares = 0; en_count = 0;
        reset = 1'b1; StartLoad = 1'b0; Abort = 1'b0; DataIn = 8'h00; DataValid = 1'b0;
        #12;
        check("rst_ready", {31'd0, DataReady}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_count", {27'd0, WordCount}, 32'd0);
        check("rst_coeff00", {24'd0, c[0]}, 32'd0);
        check("rst_offset", {24'd0, OffsetOut}, 32'd0);
        reset = 1'b0;
        step();

        // 1: words 1..21, no gaps; 6: StartLoad pokes and a 22nd word
        for (int k = 0; k < 21; k++) words[k] = 8'(k + 1);
        run_load("t1", 1'b0, 1'b1);

        // 2: same stream with DataValid gaps
        run_load("t2", 1'b1, 1'b0);

        // 3: signed extremes
        for (int k = 0; k < 21; k++) words[k] = (k % 3 == 0) ? 8'h80 : ((k % 3 == 1) ? 8'hFF : 8'h7F);
        run_load("t3", 1'b0, 1'b0);

        // 4: abort with the 8th word
        en_before = en_count;
        StartLoad = 1'b1; step(); StartLoad = 1'b0;
        for (int k = 0; k < 7; k++) begin
            DataValid = 1'b1; DataIn = 8'h11; step();
        end
        Abort = 1'b1; DataValid = 1'b1; DataIn = 8'h22; step();
        Abort = 1'b0; DataValid = 1'b0;
        check("abort_count", {27'd0, WordCount}, 32'd7);
        check("abort_ready", {31'd0, DataReady}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_partial", {24'd0, c[6]}, 32'h11);
        check("abort_word8", {24'd0, c[7]}, 32'hFF);
        step(); step();
        check("abort_no_done", {31'd0, LoadDone}, 32'd0);
        check("abort_no_en", en_count - en_before, 32'd0);
        for (int k = 0; k < 21; k++) words[k] = 8'(8'hA0 + k);
        run_load("t4", 1'b0, 1'b0);

        // 5: asynchronous reset after 10 words
        en_before = en_count;
        StartLoad = 1'b1; step(); StartLoad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            DataValid = 1'b1; DataIn = 8'h33; step();
        end
        check("t5_pre_count", {27'd0, WordCount}, 32'd10);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_coeff00", {24'd0, c[0]}, 32'd0);
        check("t5_rst_coeff19", {24'd0, c[19]}, 32'd0);
        check("t5_rst_offset", {24'd0, OffsetOut}, 32'd0);
        check("t5_rst_count", {27'd0, WordCount}, 32'd0);
        check("t5_rst_ready", {31'd0, DataReady}, 32'd0);
        check("t5_rst_busy", {31'd0, Busy}, 32'd0);
        #1 reset = 1'b0;
        step(); step(); step();
        DataValid = 1'b0;
        check("t5_idle_ready", {31'd0, DataReady}, 32'd0);
        check("t5_idle_count", {27'd0, WordCount}, 32'd0);
        check("t5_idle_coeff00", {24'd0, c[0]}, 32'd0);
        check("t5_no_en", en_count - en_before, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
